instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch-stage controller sitting directly downstream of the program counter register in the single-cycle MIPS datapath. It presents the current PC to instruction memory, waits for the memory handshake, and latches the returned word with its PC. It hands the instruction to decode through a valid/ready handshake, and drives the PC register's enable so the PC advances only once an instruction has actually been fetched or a redirect occurs.

## Interface
- No parameters; address and data width fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset; `rst`=0 resets, `rst`=1 runs.
- `pc` in 32: current PC from the PC register.
- `pc_enable` out 1: load strobe to the PC register (it loads its `pc_next`).
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; equals `pc` while `imem_req`=1.
- `imem_ready` in 1: memory has `imem_rdata` valid this cycle; ignored when `imem_req`=0.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction.
- `instr_pc` out 32: PC of the held instruction.
- `instr_valid` out 1: `instr`/`instr_pc` are valid.
- `instr_ready` in 1: decode accepts the instruction.
- `flush` in 1: discard held or in-flight fetch; the PC loads the redirect target.
- `fault` out 1: misaligned-PC fault (see Configuration).
- `instr_count` out 32: number of instructions accepted by decode.

## Operation
- FSM states: IDLE, FETCH, VALID, FAULT. Reset state is IDLE.
- **IDLE**
  - `imem_req`=0.
  - Goes to FETCH unconditionally on the next edge.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ready`=1: register `instr`←`imem_rdata` and `instr_pc`←`pc`, assert `pc_enable` for exactly that cycle, and go to VALID.
  - Otherwise stay in FETCH with `pc_enable`=0.
- **VALID**
  - `instr_valid`=1 and `imem_req`=0.
  - On `instr_ready`=1: increment `instr_count` (wraps 0xFFFFFFFF→0) and go to FETCH.
  - `instr` and `instr_pc` are stable while `instr_valid`=1 and `instr_ready`=0.
- **`flush`** (any state, highest priority)
  - `pc_enable`=1 that cycle and next state is FETCH.
  - `instr_valid` drops on the next edge.
  - A simultaneous `imem_ready` is discarded: no `instr` update.
  - A simultaneous `instr_ready` in VALID does not increment `instr_count`.
  - Flush in FETCH with `imem_ready`=1 yields exactly one `pc_enable` pulse, not two.
  - Flush in IDLE still pulses `pc_enable`.
- **`pc_enable`** = `flush` | (FETCH & `imem_ready` & ~misaligned). It is never asserted in VALID without `flush`.
- **Reset mid-operation**
  - The FSM returns to IDLE immediately (asynchronously).
  - An outstanding memory request is abandoned; `imem_ready` is ignored until FETCH is re-entered.

## Timing
- Reset values:
  - `pc_enable`=0, `imem_req`=0, `instr_valid`=0, `fault`=0.
  - `instr`=0, `instr_pc`=0, `instr_count`=0, state IDLE.
- `imem_req`/`imem_addr` are a combinational decode of the state and `pc`. The memory may respond with `imem_ready` in the same cycle (zero-wait) or any later cycle.
- `pc_enable` is combinational from the state, `imem_ready` and `flush`; it has no registered delay.
- Latency, reset release to first `imem_req`: 1 cycle (IDLE→FETCH).
- Latency, `imem_ready` to `instr_valid`: 1 cycle.
- Zero-wait memory with decode always ready gives 1 instruction per 2 cycles.
- `instr_count` updates on the edge where `instr_valid` & `instr_ready` & ~`flush`.

## Configuration
- Macro `FETCH_ALIGN_CHECK_EN`.
- **Defined:**
  - In FETCH, if `pc[1:0]`≠0, then `imem_req`=0 and `pc_enable`=0, and the FSM goes to FAULT.
  - In FAULT, `fault`=1 (sticky), `instr_valid`=0 and `imem_req`=0.
  - FAULT is left only via `flush` (→FETCH, `fault` clears on that edge) or reset.
- **Undefined:**
  - FAULT state and the check logic are absent; `fault` is tied to 0.
  - `pc` is issued unmodified regardless of alignment.

## Test plan
- **Reset/startup:** hold `rst`=0 for 3 cycles, `pc`=0x00000000 → all outputs 0. Release reset → `imem_req`=1 with `imem_addr`=0x0 one cycle later.
- **Zero-wait fetch:** `imem_ready`=1 with `imem_rdata`=0x20080005, decode ready.
  - `pc_enable` pulses once per fetch.
  - Next cycle `instr`=0x20080005, `instr_pc`=0x0, `instr_valid`=1.
  - After acceptance `instr_count`=1.
- **Memory wait states:** `imem_ready` low for 3 cycles with `pc`=0x4 → `imem_req` held for 4 cycles, `pc_enable`=0 for 3 cycles then a 1-cycle pulse.
- **Decode backpressure:** `instr_ready`=0 for 5 cycles.
  - `instr`/`instr_pc` stable, no `imem_req`, no `pc_enable`.
  - `instr_count` unchanged until `instr_ready`=1.
- **Flush collisions:** `flush` with `imem_ready`=1 in FETCH, and `flush` with `instr_ready`=1 in VALID.
  - Exactly one `pc_enable` pulse in each case.
  - `instr` not updated, `instr_count` not incremented, next state FETCH.
- **Alignment (`FETCH_ALIGN_CHECK_EN` defined):** `pc`=0x00000006.
  - `fault`=1 next cycle, with no `imem_req` and no `pc_enable`.
  - `flush` clears `fault` and resumes FETCH.
  - With the macro undefined, `imem_addr`=0x00000006 is issued.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch-stage controller between the PC register and decode.
// Presents pc to instruction memory, waits for imem_ready, latches the word
// with its PC and offers it to decode over a valid/ready handshake.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned PCs into a
// sticky FAULT state that only flush or reset can leave.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        flush,
    output logic        fault,
    output logic [31:0] instr_count
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
`endif

    state_t state, state_nxt;
    logic   misaligned;
    logic   capture;
    logic   accept;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
    assign fault      = (state == FAULT);
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
`endif

    // A flush discards any word returning or being accepted in the same cycle.
    assign capture = (state == FETCH) && imem_ready && !misaligned && !flush;
    assign accept  = (state == VALID) && instr_ready && !flush;

    assign imem_req    = (state == FETCH) && !misaligned;
    assign imem_addr   = pc;
    assign instr_valid = (state == VALID);
    // Single pulse even when flush and a memory return coincide.
    assign pc_enable   = flush || ((state == FETCH) && imem_ready && !misaligned);

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; flush overrides everything and restarts fetch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                IDLE:    state_nxt = FETCH;
                FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (misaligned)      state_nxt = FAULT;
                    else if (imem_ready) state_nxt = VALID;
`else
                    if (imem_ready)      state_nxt = VALID;
`endif
                end
                VALID:   if (instr_ready) state_nxt = FETCH;
                default: state_nxt = state;
            endcase
        end
    end

    // Instruction/PC holding register; stable while decode stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr    <= 32'h0;
            instr_pc <= 32'h0;
        end else if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    // Count of instructions handed to decode; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instr_count <= 32'h0;
        else if (accept) instr_count <= instr_count + 32'h1;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        fault;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_enable(pc_enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        rdy;
        logic [31:0] rdata;
        logic        irdy;
        logic [31:0] pc;
        logic        pen;
        logic        req;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fl, input logic rd, input logic [31:0] rdat,
                       input logic ir, input logic [31:0] p, input logic pen,
                       input logic req, input logic vld, input logic [31:0] ins,
                       input logic [31:0] ipc, input logic [31:0] cnt);
        vec_t v;
        v.flush = fl; v.rdy = rd; v.rdata = rdat; v.irdy = ir; v.pc = p;
        v.pen = pen; v.req = req; v.vld = vld; v.instr = ins; v.ipc = ipc; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic rd, input logic [31:0] rdat,
                         input logic ir, input logic [31:0] p);
        flush = fl; imem_ready = rd; imem_rdata = rdat; instr_ready = ir; pc = p;
    endtask

    initial begin
        // flush rdy rdata irdy pc | pen req vld instr ipc cnt
        add(0,0,32'h0,       0,32'h0,   0,0,0,32'h0,       32'h0,  0); // IDLE
        add(0,1,32'h20080005,1,32'h0,   1,1,0,32'h0,       32'h0,  0); // zero-wait fetch
        add(0,0,32'h0,       1,32'h4,   0,0,1,32'h20080005,32'h0,  0); // accept
        add(0,0,32'h0,       0,32'h4,   0,1,0,32'h20080005,32'h0,  1); // wait 1
        add(0,0,32'h0,       0,32'h4,   0,1,0,32'h20080005,32'h0,  1); // wait 2
        add(0,0,32'h0,       0,32'h4,   0,1,0,32'h20080005,32'h0,  1); // wait 3
        add(0,1,32'h8C090000,0,32'h4,   1,1,0,32'h20080005,32'h0,  1); // return
        for (int i = 0; i < 5; i++)                                    // backpressure
            add(0,0,32'h0,   0,32'h8,   0,0,1,32'h8C090000,32'h4,  1);
        add(0,0,32'h0,       1,32'h8,   0,0,1,32'h8C090000,32'h4,  1); // accept
        add(1,1,32'hDEADBEEF,0,32'h8,   1,1,0,32'h8C090000,32'h4,  2); // flush+ready in FETCH
        add(0,1,32'h00000020,0,32'h100, 1,1,0,32'h8C090000,32'h4,  2); // refetch
        add(1,0,32'h0,       1,32'h104, 1,0,1,32'h00000020,32'h100,2); // flush+accept in VALID
        add(0,0,32'h0,       0,32'h200, 0,1,0,32'h00000020,32'h100,2); // back in FETCH

        drive(0, 0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc_enable", {31'h0, pc_enable}, 0);
        chk("rst_imem_req", {31'h0, imem_req}, 0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 0);
        chk("rst_fault", {31'h0, fault}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_instr_count", instr_count, 0);
        rst = 1'b1;

        foreach (vq[i]) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].flush, vq[i].rdy, vq[i].rdata, vq[i].irdy, vq[i].pc);
            #1;
            chk($sformatf("v%0d_pc_enable", i), {31'h0, pc_enable}, {31'h0, vq[i].pen});
            chk($sformatf("v%0d_imem_req", i), {31'h0, imem_req}, {31'h0, vq[i].req});
            chk($sformatf("v%0d_instr_valid", i), {31'h0, instr_valid}, {31'h0, vq[i].vld});
            chk($sformatf("v%0d_instr", i), instr, vq[i].instr);
            chk($sformatf("v%0d_instr_pc", i), instr_pc, vq[i].ipc);
            chk($sformatf("v%0d_instr_count", i), instr_count, vq[i].cnt);
            chk($sformatf("v%0d_fault", i), {31'h0, fault}, 0);
            if (vq[i].req) chk($sformatf("v%0d_imem_addr", i), imem_addr, vq[i].pc);
        end

        // Asynchronous reset in the middle of a pending fetch.
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h200);
        #1;
        chk("pend_imem_req", {31'h0, imem_req}, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_imem_req", {31'h0, imem_req}, 0);
        chk("async_rst_instr", instr, 0);
        chk("async_rst_count", instr_count, 0);
        imem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready_ignored_pen", {31'h0, pc_enable}, 0);
        @(negedge clk);
        // Release into IDLE with flush: pulse but no request.
        drive(1, 1, 32'h11111111, 0, 32'h300);
        rst = 1'b1;
        #1;
        chk("idle_flush_pen", {31'h0, pc_enable}, 1);
        chk("idle_flush_req", {31'h0, imem_req}, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h300);
        #1;
        chk("after_idle_flush_req", {31'h0, imem_req}, 1);
        chk("after_idle_flush_addr", imem_addr, 32'h300);
        chk("after_idle_flush_instr", instr, 0);

        // Misaligned PC.
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h6);
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        imem_ready = 1'b1;
        #1;
        chk("mis_req", {31'h0, imem_req}, 0);
        chk("mis_pen", {31'h0, pc_enable}, 0);
        chk("mis_fault_pre", {31'h0, fault}, 0);
        @(negedge clk);
        #1;
        chk("fault_set", {31'h0, fault}, 1);
        chk("fault_req", {31'h0, imem_req}, 0);
        chk("fault_pen", {31'h0, pc_enable}, 0);
        chk("fault_valid", {31'h0, instr_valid}, 0);
        @(negedge clk);
        #1;
        chk("fault_sticky", {31'h0, fault}, 1);
        flush = 1'b1;
        #1;
        chk("fault_flush_pen", {31'h0, pc_enable}, 1);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h8);
        #1;
        chk("fault_cleared", {31'h0, fault}, 0);
        chk("fault_resume_req", {31'h0, imem_req}, 1);
        chk("fault_resume_addr", imem_addr, 32'h8);
`else
        chk("unaligned_req", {31'h0, imem_req}, 1);
        chk("unaligned_addr", imem_addr, 32'h6);
        chk("unaligned_fault", {31'h0, fault}, 0);
        imem_ready = 1'b1;
        #1;
        chk("unaligned_pen", {31'h0, pc_enable}, 1);
        @(negedge clk);
        #1;
        chk("unaligned_instr_pc", instr_pc, 32'h6);
        chk("unaligned_fault_after", {31'h0, fault}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
